// File: rtl/regfile_pkg.sv
// Shared constants and type conventions for the integer register file.
package regfile_pkg;

   localparam int XLEN_DEF  = 32;
   localparam int NREGS_DEF = 32;
   localparam int REG_ZERO  = 0;

   typedef logic [XLEN_DEF-1:0]           xlen_t;
   typedef logic [$clog2(NREGS_DEF)-1:0]  reg_addr_t;

endpackage

// File: rtl/regfile_sb_if.sv
// Bus between issue/writeback and the register file.
// There is no valid/ready pairing here: rd_en, wr_en and sb_set_en are
// single-cycle qualifiers that are always accepted on the rising edge (the
// register file never back-pressures), and every output is registered.
interface regfile_sb_if
   import regfile_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int NREGS = NREGS_DEF,
   parameter int NRD   = 2,
   parameter int AW    = $clog2(NREGS)
);

   logic [NRD-1:0]      rd_en;
   logic [NRD*AW-1:0]   rd_addr;
   logic [NRD*XLEN-1:0] rd_data;
   logic [NRD-1:0]      rd_busy;
   logic                wr_en;
   logic [AW-1:0]       wr_addr;
   logic [XLEN-1:0]     wr_data;
   logic                sb_set_en;
   logic [AW-1:0]       sb_set_addr;
   logic [NREGS-1:0]    busy_vec;

   modport master (
      output rd_en, rd_addr, wr_en, wr_addr, wr_data, sb_set_en, sb_set_addr,
      input  rd_data, rd_busy, busy_vec
   );

   modport slave (
      input  rd_en, rd_addr, wr_en, wr_addr, wr_data, sb_set_en, sb_set_addr,
      output rd_data, rd_busy, busy_vec
   );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register write-pending scoreboard. A set from issue beats a clear from
// writeback on the same register: a new producer issued while the old retired.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int NREGS = NREGS_DEF,
   parameter int AW    = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sb_set_en_i,
   input  logic [AW-1:0]    sb_set_addr_i,
   input  logic             clr_en_i,
   input  logic [AW-1:0]    clr_addr_i,
   output logic [NREGS-1:0] busy_next_o,
   output logic [NREGS-1:0] busy_vec_o
);

   logic [NREGS-1:0] busy_q;
   logic [NREGS-1:0] busy_d;

   // Next scoreboard state; x0 never goes busy, out-of-range addresses match nothing.
   always_comb begin
      busy_d = '0;
      for (int i = REG_ZERO + 1; i < NREGS; i++) begin
         busy_d[i] = (sb_set_en_i && (sb_set_addr_i == AW'(i))) ||
                     (busy_q[i] && !(clr_en_i && (clr_addr_i == AW'(i))));
      end
   end

   // Scoreboard register with synchronous reset discarding all pending entries.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   assign busy_next_o = busy_d;
   assign busy_vec_o  = busy_q;

endmodule

// File: rtl/regfile_sb.sv
// Integer register file: NRD registered read ports with write bypass, one
// write port, hardwired-zero x0 and an integrated write-pending scoreboard.
module regfile_sb
   import regfile_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int NREGS = NREGS_DEF,
   parameter int NRD   = 2,
   parameter int AW    = $clog2(NREGS)
) (
   input logic         clk,
   input logic         rst,
   regfile_sb_if.slave bus
);

   // Address space seen by the read muxes; entries beyond NREGS read as zero.
   localparam int DEPTH = 1 << AW;

   logic [XLEN-1:0]           mem_q [NREGS];
   logic [XLEN-1:0]           mem_ext [DEPTH];
   logic [DEPTH-1:0]          busy_ext;
   logic [DEPTH-1:0]          valid_ext;
   logic [NREGS-1:0]          busy_next;
   logic [NRD-1:0][XLEN-1:0]  rd_data_q;
   logic [NRD-1:0][XLEN-1:0]  rd_data_d;
   logic [NRD-1:0]            rd_busy_q;
   logic [NRD-1:0]            rd_busy_d;
   logic                      wr_ok;

   regfile_scoreboard #(
      .NREGS (NREGS),
      .AW    (AW)
   ) u_sb (
      .clk           (clk),
      .rst           (rst),
      .sb_set_en_i   (bus.sb_set_en),
      .sb_set_addr_i (bus.sb_set_addr),
      .clr_en_i      (bus.wr_en),
      .clr_addr_i    (bus.wr_addr),
      .busy_next_o   (busy_next),
      .busy_vec_o    (bus.busy_vec)
   );

   // Pad storage and scoreboard out to the full address space so unused
   // addresses of a non-power-of-two file read as 0 / not busy.
   for (genvar i = 0; i < DEPTH; i++) begin : g_ext
      if (i < NREGS) begin : g_real
         assign mem_ext[i]   = mem_q[i];
         assign busy_ext[i]  = busy_next[i];
         assign valid_ext[i] = 1'b1;
      end else begin : g_pad
         assign mem_ext[i]   = '0;
         assign busy_ext[i]  = 1'b0;
         assign valid_ext[i] = 1'b0;
      end
   end

   // A write only takes effect for an existing, non-zero register.
   assign wr_ok = bus.wr_en && valid_ext[bus.wr_addr] &&
                  (bus.wr_addr != AW'(REG_ZERO));

   // Storage array; x0 is never written so it stays at its reset value of 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            mem_q[i] <= '0;
         end
      end else if (wr_ok) begin
         mem_q[bus.wr_addr] <= bus.wr_data;
      end
   end

   // Per-port read mux with same-cycle write bypass.
   for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [AW-1:0] addr;
      logic          hit;
      assign addr         = bus.rd_addr[k*AW +: AW];
      assign hit          = wr_ok && (bus.wr_addr == addr);
      assign rd_data_d[k] = hit ? bus.wr_data : mem_ext[addr];
      assign rd_busy_d[k] = busy_ext[addr];
   end

   // Read output registers: load on rd_en, otherwise hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data_q <= '0;
         rd_busy_q <= '0;
      end else begin
         for (int k = 0; k < NRD; k++) begin
            if (bus.rd_en[k]) begin
               rd_data_q[k] <= rd_data_d[k];
               rd_busy_q[k] <= rd_busy_d[k];
            end
         end
      end
   end

   assign bus.rd_data = rd_data_q;
   assign bus.rd_busy = rd_busy_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed steps then random traffic on a 32x32/2-port
// instance against a register-level reference model, plus directed checks on
// a 24x64/3-port instance.
module tb_regfile_sb;

   localparam int XA = 32;
   localparam int NA = 32;
   localparam int RA = 2;
   localparam int AA = 5;
   localparam int XB = 64;
   localparam int NB = 24;
   localparam int RB = 3;
   localparam int AB = 5;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   regfile_sb_if #(.XLEN(XA), .NREGS(NA), .NRD(RA)) a_if ();
   regfile_sb_if #(.XLEN(XB), .NREGS(NB), .NRD(RB)) b_if ();

   regfile_sb #(.XLEN(XA), .NREGS(NA), .NRD(RA)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (a_if.slave)
   );

   regfile_sb #(.XLEN(XB), .NREGS(NB), .NRD(RB)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (b_if.slave)
   );

   int checks = 0;
   int errors = 0;

   // ---------------- reference model for instance A ----------------
   // Architectural view: after each edge the register file holds the new
   // contents, and a read returns what the register holds after that edge.
   logic [XA-1:0] m_mem [NA];
   logic [NA-1:0] m_busy;
   logic [XA-1:0] exp_rd [RA];
   logic          exp_bz [RA];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_step();
      int wa;
      int sa;
      int ra;
      if (rst) begin
         for (int i = 0; i < NA; i++) m_mem[i] = '0;
         m_busy = '0;
         for (int k = 0; k < RA; k++) begin
            exp_rd[k] = '0;
            exp_bz[k] = 1'b0;
         end
      end else begin
         wa = int'(a_if.wr_addr);
         sa = int'(a_if.sb_set_addr);
         if (a_if.wr_en && wa != 0 && wa < NA) begin
            m_mem[wa]  = a_if.wr_data;
            m_busy[wa] = 1'b0;
         end
         if (a_if.sb_set_en && sa != 0 && sa < NA) m_busy[sa] = 1'b1;
         for (int k = 0; k < RA; k++) begin
            if (a_if.rd_en[k]) begin
               ra = int'(a_if.rd_addr[k*AA +: AA]);
               exp_rd[k] = (ra < NA) ? m_mem[ra] : '0;
               exp_bz[k] = (ra < NA) ? m_busy[ra] : 1'b0;
            end
         end
      end
   endtask

   // One clock: model the edge, take it, then compare instance A outputs.
   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      for (int k = 0; k < RA; k++) begin
         check($sformatf("a_rd_data%0d", k), 64'(a_if.rd_data[k*XA +: XA]), 64'(exp_rd[k]));
         check($sformatf("a_rd_busy%0d", k), 64'(a_if.rd_busy[k]), 64'(exp_bz[k]));
      end
      check("a_busy_vec", 64'(a_if.busy_vec), 64'(m_busy));
   endtask

   // ---------------- driver tasks ----------------
   task automatic idle();
      a_if.rd_en = '0; a_if.wr_en = 1'b0; a_if.sb_set_en = 1'b0;
      b_if.rd_en = '0; b_if.wr_en = 1'b0; b_if.sb_set_en = 1'b0;
   endtask

   task automatic a_rd(input int k, input int addr);
      a_if.rd_en[k] = 1'b1;
      a_if.rd_addr[k*AA +: AA] = AA'(addr);
   endtask

   task automatic a_wr(input int addr, input logic [XA-1:0] data);
      a_if.wr_en = 1'b1; a_if.wr_addr = AA'(addr); a_if.wr_data = data;
   endtask

   task automatic a_set(input int addr);
      a_if.sb_set_en = 1'b1; a_if.sb_set_addr = AA'(addr);
   endtask

   task automatic b_rd(input int k, input int addr);
      b_if.rd_en[k] = 1'b1;
      b_if.rd_addr[k*AB +: AB] = AB'(addr);
   endtask

   task automatic b_wr(input int addr, input logic [XB-1:0] data);
      b_if.wr_en = 1'b1; b_if.wr_addr = AB'(addr); b_if.wr_data = data;
   endtask

   task automatic b_set(input int addr);
      b_if.sb_set_en = 1'b1; b_if.sb_set_addr = AB'(addr);
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      rst = 1'b1;
      a_if.rd_addr = '0; a_if.wr_addr = '0; a_if.wr_data = '0; a_if.sb_set_addr = '0;
      b_if.rd_addr = '0; b_if.wr_addr = '0; b_if.wr_data = '0; b_if.sb_set_addr = '0;
      idle();

      // Reset for two cycles, then read every register on both ports.
      tick();
      tick();
      rst = 1'b0;
      for (int r = 1; r < NA; r++) begin
         idle(); a_rd(0, r); a_rd(1, r);
         tick();
      end
      check("reset_busy_vec", 64'(a_if.busy_vec), 64'h0);
      check("reset_rd_data1", 64'(a_if.rd_data[XA +: XA]), 64'h0);

      // Write then read.
      idle(); a_wr(5, 32'hDEADBEEF); tick();
      idle(); a_rd(0, 5); tick();
      check("wr_rd_x5", 64'(a_if.rd_data[0 +: XA]), 64'hDEADBEEF);
      idle(); a_wr(0, 32'h1234); tick();
      idle(); a_rd(0, 0); tick();
      check("x0_zero", 64'(a_if.rd_data[0 +: XA]), 64'h0);

      // Bypass on both ports reading the register being written.
      idle(); a_wr(7, 32'h11); tick();
      idle(); a_wr(7, 32'hA5A5A5A5); a_rd(0, 7); a_rd(1, 7); tick();
      check("bypass_p0", 64'(a_if.rd_data[0 +: XA]), 64'hA5A5A5A5);
      check("bypass_p1", 64'(a_if.rd_data[XA +: XA]), 64'hA5A5A5A5);

      // Scoreboard set, clear with read bypass, set-wins, x0 never busy.
      idle(); a_set(9); tick();
      check("sb_set_x9", 64'(a_if.busy_vec[9]), 64'h1);
      idle(); a_rd(0, 9); tick();
      check("rd_busy_x9", 64'(a_if.rd_busy[0]), 64'h1);
      idle(); a_wr(9, 32'h99); a_rd(0, 9); tick();
      check("clr_rd_busy_x9", 64'(a_if.rd_busy[0]), 64'h0);
      check("clr_rd_data_x9", 64'(a_if.rd_data[0 +: XA]), 64'h99);
      idle(); a_set(9); a_wr(9, 32'h77); tick();
      check("set_wins_x9", 64'(a_if.busy_vec[9]), 64'h1);
      idle(); a_wr(9, 32'h78); tick();
      idle(); a_set(0); tick();
      check("sb_set_x0", 64'(a_if.busy_vec), 64'h0);

      // Hold with rd_en low, then reset mid-operation.
      idle(); a_wr(3, 32'h42); tick();
      idle(); a_set(3); tick();
      idle(); a_rd(0, 3); tick();
      for (int c = 0; c < 3; c++) begin
         idle(); a_wr(3, 32'h500 + 32'(c)); tick();
         check("hold_data", 64'(a_if.rd_data[0 +: XA]), 64'h42);
         check("hold_busy", 64'(a_if.rd_busy[0]), 64'h1);
      end
      idle(); a_set(12); a_rd(1, 3); rst = 1'b1; tick();
      rst = 1'b0;
      check("rst_mid_busy_vec", 64'(a_if.busy_vec), 64'h0);
      check("rst_mid_rd_data0", 64'(a_if.rd_data[0 +: XA]), 64'h0);
      check("rst_mid_rd_busy0", 64'(a_if.rd_busy[0]), 64'h0);

      // 24-entry, 64-bit, 3-port instance.
      idle(); b_wr(30, 64'hFFFF_0000_FFFF_0000); b_set(30); tick();
      idle(); b_rd(0, 30); tick();
      check("b_rd30_data", b_if.rd_data[0 +: XB], 64'h0);
      check("b_rd30_busy", 64'(b_if.rd_busy[0]), 64'h0);
      check("b_busy_vec_30", 64'(b_if.busy_vec), 64'h0);
      idle(); b_wr(4, 64'h0123456789ABCDEF); tick();
      idle(); b_rd(0, 4); b_rd(1, 4); b_rd(2, 4); tick();
      for (int k = 0; k < RB; k++) begin
         check($sformatf("b_rt_p%0d", k), b_if.rd_data[k*XB +: XB], 64'h0123456789ABCDEF);
      end
      idle(); b_set(5); tick();
      idle(); b_rd(1, 5); b_rd(2, 23); b_wr(23, 64'hCAFE); tick();
      check("b_busy_x5", 64'(b_if.rd_busy[1]), 64'h1);
      check("b_busy_vec_x5", 64'(b_if.busy_vec), 64'h20);
      check("b_bypass_x23", b_if.rd_data[2*XB +: XB], 64'hCAFE);

      // Random traffic on instance A, clustered addresses to force hazards.
      for (int n = 0; n < 400; n++) begin
         idle();
         rst = ($urandom_range(0, 79) == 0);
         a_if.wr_en       = $urandom_range(0, 1) == 1;
         a_if.wr_addr     = AA'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, NA - 1));
         a_if.wr_data     = $urandom;
         a_if.sb_set_en   = $urandom_range(0, 2) == 0;
         a_if.sb_set_addr = AA'($urandom_range(0, 7));
         for (int k = 0; k < RA; k++) begin
            a_if.rd_en[k] = $urandom_range(0, 3) != 0;
            if ($urandom_range(0, 3) == 0) a_if.rd_addr[k*AA +: AA] = a_if.wr_addr;
            else a_if.rd_addr[k*AA +: AA] = AA'($urandom_range(0, 9));
         end
         tick();
      end
      rst = 1'b0;
      idle();
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised integer register file with an integrated write-pending scoreboard for the RISC-V core. It sits between decode/issue and writeback. It provides NRD registered read ports, one write port with same-cycle write-to-read bypass, and a hardwired-zero x0. A per-register busy scoreboard lets issue detect RAW hazards on operands whose producer has not yet written back.

## Interface
- XLEN, 32, register width in bits
- NREGS, 32, number of architectural registers (2..64)
- NRD, 2, number of read ports (1..4)
- AW, $clog2(NREGS), register address width
- clk  in  1  clock, rising-edge
- rst  in  1  reset, synchronous, active-high
- rd_en  in  NRD  per-port read enable
- rd_addr  in  NRD*AW  read addresses, port k at [k*AW +: AW]
- rd_data  out  NRD*XLEN  registered read data, port k at [k*XLEN +: XLEN]
- rd_busy  out  NRD  registered busy flag for the register read on port k
- wr_en  in  1  writeback enable
- wr_addr  in  AW  writeback register
- wr_data  in  XLEN  writeback value
- sb_set_en  in  1  issue marks a destination register pending
- sb_set_addr  in  AW  destination being marked
- busy_vec  out  NREGS  current scoreboard state, bit i = register i pending

## Operation
- Storage: NREGS x XLEN flops. Register 0 always reads 0. Writes to 0 are dropped. Register 0 is never busy.
- Addresses >= NREGS (non-power-of-two NREGS) read 0 with busy 0. Writes or sets to such addresses are ignored.
- Write: when wr_en=1, wr_data is stored at wr_addr on the rising edge.
- Read: when rd_en[k]=1, rd_data[k] loads mem[rd_addr[k]] on the edge. If wr_en=1 and wr_addr==rd_addr[k]!=0 in the same cycle, rd_data[k] loads wr_data (bypass). When rd_en[k]=0, rd_data[k] and rd_busy[k] hold their values.
- Multiple ports may read the same address in the same cycle. Every such port gets an identical result.
- Scoreboard update per edge, for register i != 0:
  - busy_next[i] = set_i | (busy[i] & ~clr_i)
  - set_i = sb_set_en & sb_set_addr==i
  - clr_i = wr_en & wr_addr==i
  - When set and clear hit the same register, set wins: a new producer has issued while the old one retires.
- rd_busy[k] loads busy_next[rd_addr[k]] when rd_en[k]=1. It therefore reflects the same-edge clear and set, consistent with the data bypass.
- A write to a non-busy register is legal: data is stored and busy stays 0.

## Timing
- Read latency is 1 cycle: address at edge N gives rd_data and rd_busy valid after edge N.
- Write-to-read visibility is 0 cycles through the bypass. Write data is stored and visible after the same edge.
- busy_vec is the registered scoreboard. Set or clear at edge N is visible in busy_vec after edge N.
- Reset: while rst=1 at an edge, the following clear to 0 and all other inputs are ignored that cycle:
  - all registers
  - busy_vec
  - rd_data
  - rd_busy
- Reset mid-operation discards pending scoreboard entries. The first accepted operation is on the edge after rst deasserts.
- There are no combinational paths from inputs to outputs.

## Structure
- Shared package regfile_pkg:
  - default XLEN and NREGS
  - the reg_addr_t / xlen_t typedef convention
  - constant REG_ZERO = 0
- Sub-module regfile_scoreboard (NREGS, AW):
  - holds busy_vec
  - implements the set-wins update
  - exports busy_next for the read-port muxes
- The top level holds the storage array, the NRD read muxes (generate loop) and the bypass compare.

## Test plan
- Reset then read: assert rst 2 cycles, then read x1..x31 on both ports -> every rd_data=0, rd_busy=0, busy_vec=0.
- Write then read: write x5=0xDEADBEEF, next cycle rd_addr[0]=5 -> rd_data[0]=0xDEADBEEF one cycle after the request. Write x0=0x1234 -> reading x0 returns 0.
- Bypass: in one cycle, wr_en x7=0xA5A5A5A5 and rd_addr[0]=rd_addr[1]=7 (old value 0x11) -> both ports return 0xA5A5A5A5.
- Scoreboard:
  - sb_set x9 -> busy_vec[9]=1, and a read of x9 gives rd_busy=1.
  - A later write to x9 in the same cycle as a read of x9 -> rd_busy=0, with the new data.
  - Set and write x9 in one cycle -> busy_vec[9]=1.
  - sb_set x0 -> busy_vec stays 0.
- Hold and reset mid-op: set x3 busy, read x3 with data 0x42, then rd_en=0 for 3 cycles with writes to x3 -> outputs hold 0x42 and busy 1. Then assert rst -> all outputs and busy_vec read 0 after the edge.
- Parametrisation: NREGS=24, NRD=3, XLEN=64 build -> read of address 30 returns 0 with busy 0; a write to 30 is dropped; 64-bit value 0x0123456789ABCDEF round-trips on all 3 ports.
